// File: rtl/vga_dolgu_motoru_pkg.sv
// Shared definitions for the rectangle-fill engine.
// Holds register word indices (wb adr[3:2]), KONTROL/DURUM bit positions,
// FSM state encoding, default screen size and the coordinate clamp helper.
package vga_dolgu_motoru_pkg;

    localparam int GENISLIK_VARSAYILAN  = 640;
    localparam int YUKSEKLIK_VARSAYILAN = 480;

    localparam logic [1:0] REG_BASLANGIC = 2'd0;
    localparam logic [1:0] REG_BITIS     = 2'd1;
    localparam logic [1:0] REG_KONTROL   = 2'd2;
    localparam logic [1:0] REG_DURUM     = 2'd3;

    localparam int KONTROL_RENK   = 0;
    localparam int KONTROL_BASLAT = 1;
    localparam int KONTROL_IPTAL  = 2;

    localparam int DURUM_MESGUL = 0;
    localparam int DURUM_BITTI  = 1;
    localparam int DURUM_HATA   = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_YAZ   = 2'd1,
        S_BEKLE = 2'd2
    } durum_e;

    function automatic logic [9:0] doyur(input logic [9:0] deger, input logic [9:0] tavan);
        return (deger > tavan) ? tavan : deger;
    endfunction

endpackage

// File: rtl/vga_dolgu_motoru_if.sv
// Wishbone classic bus bundle used for both the CPU-facing register port
// (slave) and the frame-buffer port (master).
// Signals: adr, dat_w (master->slave), dat_r (slave->master), sel, we,
// cyc, stb, ack. Address width is set per instance through AW.
interface vga_dolgu_motoru_if #(
    parameter int AW = 4
);
    logic [AW-1:0] adr;
    logic [31:0]   dat_w;
    logic [31:0]   dat_r;
    logic [3:0]    sel;
    logic          we;
    logic          cyc;
    logic          stb;
    logic          ack;

    modport master (output adr, dat_w, sel, we, cyc, stb, input ack);
    modport slave  (input adr, dat_w, sel, we, cyc, stb, output ack, dat_r);
endinterface

// File: rtl/vga_dolgu_motoru_sayac.sv
// vga_dolgu_sayaci: x/y cursor of the fill engine.
// Clamps the raw rectangle corners to the screen, flags an empty rectangle
// (gecersiz), loads the cursor on yukle and advances it on ilerle with y as
// the inner loop. son marks the last pixel; kalan is the pixel count left in
// the current column including the current one.
// Ports: clk_i, rst_i, yukle, ilerle, ham_x0/x1 (10b), ham_y0/y1 (9b),
//        gecersiz, x (10b), y (9b), son, kalan (16b).
module vga_dolgu_sayaci
    import vga_dolgu_motoru_pkg::*;
#(
    parameter int GENISLIK  = GENISLIK_VARSAYILAN,
    parameter int YUKSEKLIK = YUKSEKLIK_VARSAYILAN
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        yukle,
    input  logic        ilerle,
    input  logic [9:0]  ham_x0,
    input  logic [9:0]  ham_x1,
    input  logic [8:0]  ham_y0,
    input  logic [8:0]  ham_y1,
    output logic        gecersiz,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic        son,
    output logic [15:0] kalan
);
    localparam logic [9:0] X_MAX = 10'(GENISLIK - 1);
    localparam logic [8:0] Y_MAX = 9'(YUKSEKLIK - 1);

    logic [9:0] x0_c, x1_c, x_son;
    logic [8:0] y0_c, y1_c, y_bas, y_son;
    logic [9:0] kalan_y;

    assign x0_c = doyur(ham_x0, X_MAX);
    assign x1_c = doyur(ham_x1, X_MAX);
    assign y0_c = (ham_y0 > Y_MAX) ? Y_MAX : ham_y0;
    assign y1_c = (ham_y1 > Y_MAX) ? Y_MAX : ham_y1;

    assign gecersiz = (x0_c > x1_c) || (y0_c > y1_c);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x     <= '0;
            y     <= '0;
            y_bas <= '0;
            x_son <= '0;
            y_son <= '0;
        end else if (yukle) begin
            x     <= x0_c;
            y     <= y0_c;
            y_bas <= y0_c;
            x_son <= x1_c;
            y_son <= y1_c;
        end else if (ilerle) begin
            if (y == y_son) begin
                y <= y_bas;
                x <= x + 10'd1;
            end else begin
                y <= y + 9'd1;
            end
        end
    end

    assign son     = (x == x_son) && (y == y_son);
    assign kalan_y = {1'b0, y_son} - {1'b0, y} + 10'd1;
    assign kalan   = {6'd0, kalan_y};
endmodule

// File: rtl/vga_dolgu_motoru.sv
// vga_dolgu_motoru: rectangle-fill engine in front of the VGA frame buffer.
// The CPU programs corners and colour over the wb slave port; the engine then
// writes one pixel per wbm transaction at address {x, y}, data {31'b0, colour}.
// Ports: clk_i, rst_i (sync, active high), wb (register slave, AW=4),
//        wbm (frame-buffer master, AW=19).
//
// state   | meaning
// S_IDLE  | no bus traffic, waiting for start
// S_YAZ   | cyc/stb high on current pixel until ack
// S_BEKLE | one idle bus cycle, sets done, then back to idle
module vga_dolgu_motoru
    import vga_dolgu_motoru_pkg::*;
#(
    parameter int GENISLIK  = GENISLIK_VARSAYILAN,
    parameter int YUKSEKLIK = YUKSEKLIK_VARSAYILAN
) (
    input logic                clk_i,
    input logic                rst_i,
    vga_dolgu_motoru_if.slave  wb,
    vga_dolgu_motoru_if.master wbm
);
    durum_e      durum, durum_sonraki;
    logic [9:0]  x0_r, x1_r, x;
    logic [8:0]  y0_r, y1_r, y;
    logic        renk_r, renk_aktif, baslat_q, iptal_q, bitti_r, hata_r, ack_r;
    logic [31:0] oku_r, oku_mux;
    logic        kabul, yazma, mesgul, yukle, ilerle, gecersiz, son;
    logic [1:0]  reg_sec;
    logic [15:0] kalan;
    logic        unused_bitler;

    assign reg_sec = wb.adr[3:2];
    assign kabul   = wb.cyc & wb.stb & ~ack_r;
    assign yazma   = kabul & wb.we;
    assign mesgul  = (durum != S_IDLE);
    assign unused_bitler = ^{wb.sel, wb.adr[1:0], wb.dat_w[31:25], wb.dat_w[15:10]};

    always_comb begin
        oku_mux = '0;
        case (reg_sec)
            REG_BASLANGIC: oku_mux = {7'd0, y0_r, 6'd0, x0_r};
            REG_BITIS:     oku_mux = {7'd0, y1_r, 6'd0, x1_r};
            REG_KONTROL:   oku_mux[KONTROL_RENK] = renk_r;
            default: begin
                oku_mux[31:16]        = mesgul ? kalan : 16'd0;
                oku_mux[DURUM_MESGUL] = mesgul;
                oku_mux[DURUM_BITTI]  = bitti_r;
                oku_mux[DURUM_HATA]   = hata_r;
            end
        endcase
    end

    always_comb begin
        durum_sonraki = durum;
        yukle         = 1'b0;
        ilerle        = 1'b0;
        case (durum)
            S_IDLE: begin
                if (baslat_q && !gecersiz) begin
                    yukle         = 1'b1;
                    durum_sonraki = S_YAZ;
                end
            end
            S_YAZ: begin
                if (wbm.ack) begin
                    if (son || iptal_q) durum_sonraki = S_BEKLE;
                    else                ilerle        = 1'b1;
                end
            end
            S_BEKLE: durum_sonraki = S_IDLE;
            default: durum_sonraki = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum      <= S_IDLE;
            x0_r       <= '0;
            y0_r       <= '0;
            x1_r       <= '0;
            y1_r       <= '0;
            renk_r     <= 1'b0;
            renk_aktif <= 1'b0;
            baslat_q   <= 1'b0;
            iptal_q    <= 1'b0;
            bitti_r    <= 1'b0;
            hata_r     <= 1'b0;
            ack_r      <= 1'b0;
            oku_r      <= '0;
        end else begin
            durum    <= durum_sonraki;
            ack_r    <= kabul;
            baslat_q <= 1'b0;
            if (kabul) oku_r <= oku_mux;

            // Geometry and colour are frozen for the whole fill.
            if (yazma && !mesgul) begin
                if (reg_sec == REG_BASLANGIC) begin
                    x0_r <= wb.dat_w[9:0];
                    y0_r <= wb.dat_w[24:16];
                end
                if (reg_sec == REG_BITIS) begin
                    x1_r <= wb.dat_w[9:0];
                    y1_r <= wb.dat_w[24:16];
                end
                if (reg_sec == REG_KONTROL) begin
                    renk_r   <= wb.dat_w[KONTROL_RENK];
                    baslat_q <= wb.dat_w[KONTROL_BASLAT];
                end
            end

            // Abort only matters while pixels are being written; drop it on exit
            // so a late abort cannot leak into the next fill.
            if (durum_sonraki != S_YAZ)
                iptal_q <= 1'b0;
            else if (durum == S_YAZ && yazma && reg_sec == REG_KONTROL && wb.dat_w[KONTROL_IPTAL])
                iptal_q <= 1'b1;

            if (durum == S_IDLE && baslat_q) begin
                if (gecersiz) begin
                    hata_r <= 1'b1;
                end else begin
                    hata_r     <= 1'b0;
                    bitti_r    <= 1'b0;
                    renk_aktif <= renk_r;
                end
            end
            if (durum == S_BEKLE) bitti_r <= 1'b1;
        end
    end

    vga_dolgu_sayaci #(
        .GENISLIK (GENISLIK),
        .YUKSEKLIK(YUKSEKLIK)
    ) u_sayac (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .yukle   (yukle),
        .ilerle  (ilerle),
        .ham_x0  (x0_r),
        .ham_x1  (x1_r),
        .ham_y0  (y0_r),
        .ham_y1  (y1_r),
        .gecersiz(gecersiz),
        .x       (x),
        .y       (y),
        .son     (son),
        .kalan   (kalan)
    );

    assign wb.ack    = ack_r;
    assign wb.dat_r  = oku_r;

    assign wbm.cyc   = (durum == S_YAZ);
    assign wbm.stb   = (durum == S_YAZ);
    assign wbm.we    = (durum == S_YAZ);
    assign wbm.sel   = 4'b0001;
    assign wbm.adr   = {x, y};
    assign wbm.dat_w = {31'd0, renk_aktif};
endmodule
